// File: rtl/prio_pkg.sv
// Shared definitions for the priority grant path: request-line geometry, code limits and FSM state encoding.
package prio_pkg;
  localparam int unsigned N_REQ  = 10;
  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] CODE_NONE = 4'd0;
  localparam logic [CODE_W-1:0] CODE_MAX  = 4'd10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_FST = 2'd1,
    GNT_SND = 2'd2
  } state_t;
endpackage

// File: rtl/prio_code_decode.sv
// Combinational priority code to one-hot decoder: code k (1..N) selects line k-1, 0 selects nothing,
// codes above N flag invalid and decode to all-zero.
module prio_code_decode #(
  parameter int unsigned N = 10,
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] code,
  output logic [N-1:0] onehot,
  output logic         invalid
);
  import prio_pkg::*;

  always_comb begin
    onehot  = '0;
    invalid = (code > W'(N));
    for (int unsigned i = 0; i < N; i++) begin
      onehot[i] = (code == W'(i + 1));
    end
  end
endmodule

// File: rtl/prio_grant_sequencer.sv
// Turns a (fst, snd) priority code pair into sequential one-hot grants, each held until acknowledged.
// Optional ack watchdog enabled by defining PRIO_GNT_TIMEOUT_EN.
module prio_grant_sequencer #(
  parameter int unsigned N_REQ   = prio_pkg::N_REQ,
  parameter int unsigned CODE_W  = prio_pkg::CODE_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] fst,
  input  logic [CODE_W-1:0] snd,
  output logic [N_REQ-1:0]  gnt,
  output logic              gnt_valid,
  input  logic              gnt_ack,
  output logic              err
);
  import prio_pkg::*;

  state_t             state;
  logic [N_REQ-1:0]   snd_gnt;
  logic [N_REQ-1:0]   fst_oh;
  logic [N_REQ-1:0]   snd_oh;
  logic               fst_inv;
  logic               snd_inv;
  logic               handshake;
  logic               fst_live;
  logic               snd_live;
  logic               pair_err;
  logic               ack;
  logic               timeout_hit;
  logic               timeout_err;

  prio_code_decode #(.N(N_REQ), .W(CODE_W)) u_fst_dec (
    .code(fst), .onehot(fst_oh), .invalid(fst_inv)
  );

  prio_code_decode #(.N(N_REQ), .W(CODE_W)) u_snd_dec (
    .code(snd), .onehot(snd_oh), .invalid(snd_inv)
  );

  assign in_ready  = (state == IDLE);
  assign handshake = in_valid && in_ready;
  assign fst_live  = |fst_oh;
  assign snd_live  = (|snd_oh) && (snd != fst);
  // Invalid codes decode to zero, so a bad fst with a good snd also lands in the "snd without fst" case.
  assign pair_err  = fst_inv || snd_inv || (fst_live && (snd == fst)) || (!fst_live && (|snd_oh));
  assign ack       = gnt_valid && (gnt_ack || timeout_hit);
  assign timeout_err = timeout_hit && !gnt_ack;

`ifdef PRIO_GNT_TIMEOUT_EN
  logic [3:0] wd_cnt;
  logic       grant_load;

  assign grant_load  = (handshake && fst_live) || ((state == GNT_FST) && ack && (|snd_gnt));
  assign timeout_hit = gnt_valid && (wd_cnt == 4'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (grant_load) begin
      wd_cnt <= '0;
    end else if (gnt_valid && !gnt_ack) begin
      wd_cnt <= wd_cnt + 4'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  if (TIMEOUT > 15) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      err       <= 1'b0;
      snd_gnt   <= '0;
    end else begin
      err <= timeout_err;
      case (state)
        IDLE: begin
          if (handshake) begin
            err <= pair_err;
            if (fst_live) begin
              gnt       <= fst_oh;
              gnt_valid <= 1'b1;
              snd_gnt   <= snd_live ? snd_oh : '0;
              state     <= GNT_FST;
            end
          end
        end
        GNT_FST: begin
          if (ack) begin
            snd_gnt <= '0;
            if (|snd_gnt) begin
              gnt   <= snd_gnt;
              state <= GNT_SND;
            end else begin
              gnt       <= '0;
              gnt_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        GNT_SND: begin
          if (ack) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          gnt       <= '0;
          gnt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prio_grant_sequencer.sv
// Directed bench for prio_grant_sequencer: table of single-pair transactions plus multi-cycle corner sequences.
module tb_prio_grant_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] fst;
  logic [3:0] snd;
  logic [9:0] gnt;
  logic       gnt_valid;
  logic       gnt_ack;
  logic       err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] fst;
    logic [3:0] snd;
    logic [9:0] g1;
    logic [9:0] g2;
    logic       e;
  } vec_t;

  vec_t vecs[9];

  prio_grant_sequencer #(.N_REQ(10), .CODE_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fst(fst), .snd(snd), .gnt(gnt), .gnt_valid(gnt_valid),
    .gnt_ack(gnt_ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [9:0] exp_gnt, input logic exp_err);
    check({name, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({name, ".gnt_valid"}, 32'(gnt_valid), 32'(exp_gnt != 10'd0));
    check({name, ".err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic send(input logic [3:0] f, input logic [3:0] s);
    fst = f; snd = s; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; fst = 4'd0; snd = 4'd0;
  endtask

  initial begin
    vecs[0] = '{fst: 4'd10, snd: 4'd4,  g1: 10'b1000000000, g2: 10'b0000001000, e: 1'b0};
    vecs[1] = '{fst: 4'd1,  snd: 4'd0,  g1: 10'b0000000001, g2: 10'b0000000000, e: 1'b0};
    vecs[2] = '{fst: 4'd0,  snd: 4'd0,  g1: 10'b0000000000, g2: 10'b0000000000, e: 1'b0};
    vecs[3] = '{fst: 4'd12, snd: 4'd0,  g1: 10'b0000000000, g2: 10'b0000000000, e: 1'b1};
    vecs[4] = '{fst: 4'd3,  snd: 4'd3,  g1: 10'b0000000100, g2: 10'b0000000000, e: 1'b1};
    vecs[5] = '{fst: 4'd5,  snd: 4'd13, g1: 10'b0000010000, g2: 10'b0000000000, e: 1'b1};
    vecs[6] = '{fst: 4'd0,  snd: 4'd7,  g1: 10'b0000000000, g2: 10'b0000000000, e: 1'b1};
    vecs[7] = '{fst: 4'd7,  snd: 4'd10, g1: 10'b0001000000, g2: 10'b1000000000, e: 1'b0};
    vecs[8] = '{fst: 4'd15, snd: 4'd2,  g1: 10'b0000000000, g2: 10'b0000000000, e: 1'b1};

    reset = 1'b1; in_valid = 1'b0; fst = 4'd0; snd = 4'd0; gnt_ack = 1'b0;
    tick; tick;
    check_out("reset_state", 10'd0, 1'b0);
    reset = 1'b0;
    tick;
    check("reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].fst, vecs[i].snd);
      check_out($sformatf("v%0d_g1", i), vecs[i].g1, vecs[i].e);
      if (vecs[i].g1 != 10'd0) begin
        check($sformatf("v%0d_busy", i), 32'(in_ready), 32'd0);
        repeat (2) begin tick; check_out($sformatf("v%0d_hold1", i), vecs[i].g1, 1'b0); end
        gnt_ack = 1'b1; tick; gnt_ack = 1'b0;
        check_out($sformatf("v%0d_g2", i), vecs[i].g2, 1'b0);
        if (vecs[i].g2 != 10'd0) begin
          repeat (2) begin tick; check_out($sformatf("v%0d_hold2", i), vecs[i].g2, 1'b0); end
          gnt_ack = 1'b1; tick; gnt_ack = 1'b0;
          check_out($sformatf("v%0d_done", i), 10'd0, 1'b0);
        end
      end
      check($sformatf("v%0d_ready", i), 32'(in_ready), 32'd1);
      tick;
      check_out($sformatf("v%0d_idle", i), 10'd0, 1'b0);
    end

    // fst=0, snd=0 held valid for several cycles: nothing happens
    fst = 4'd0; snd = 4'd0; in_valid = 1'b1;
    repeat (3) begin
      tick;
      check_out("zero_held", 10'd0, 1'b0);
      check("zero_held_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;

    // in_valid pulsed during GNT_FST must not capture a pair
    send(4'd2, 4'd0);
    check_out("busy_g1", 10'b0000000010, 1'b0);
    fst = 4'd6; snd = 4'd1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; fst = 4'd0; snd = 4'd0;
    check_out("busy_ignored", 10'b0000000010, 1'b0);
    gnt_ack = 1'b1; tick; gnt_ack = 1'b0;
    check_out("busy_done", 10'd0, 1'b0);
    tick;
    check_out("busy_no_capture", 10'd0, 1'b0);
    check("busy_ready", 32'(in_ready), 32'd1);

    // ack in IDLE is ignored
    gnt_ack = 1'b1;
    repeat (2) begin tick; check_out("idle_ack", 10'd0, 1'b0); end
    gnt_ack = 1'b0;
    check("idle_ack_ready", 32'(in_ready), 32'd1);

    // asynchronous reset mid-grant discards the pending snd
    send(4'd4, 4'd6);
    check_out("rst_g1", 10'b0000001000, 1'b0);
    #3 reset = 1'b1;
    #1 check_out("rst_async", 10'd0, 1'b0);
    tick;
    reset = 1'b0;
    tick;
    check("rst_ready", 32'(in_ready), 32'd1);
    gnt_ack = 1'b1; tick; gnt_ack = 1'b0;
    check_out("rst_snd_dropped", 10'd0, 1'b0);

    send(4'd5, 4'd0);
    check_out("wd_g1", 10'b0000010000, 1'b0);
`ifdef PRIO_GNT_TIMEOUT_EN
    repeat (15) begin tick; check_out("wd_hold", 10'b0000010000, 1'b0); end
    tick;
    check_out("wd_expire", 10'd0, 1'b1);
    check("wd_ready", 32'(in_ready), 32'd1);
    tick;
    check_out("wd_after", 10'd0, 1'b0);
`else
    repeat (20) begin tick; check_out("hold_forever", 10'b0000010000, 1'b0); end
    gnt_ack = 1'b1; tick; gnt_ack = 1'b0;
    check_out("hold_release", 10'd0, 1'b0);
    check("hold_ready", 32'(in_ready), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
